wordcount_stream_ctrl: RTL and testbench

WORDCOUNT_STREAM_CTRL -- requirements
Module: wordcount_stream_ctrl

---
 rtl/wordcount_pkg.sv | 11 +
 rtl/wordcount_beat_splitter.sv | 56 +++++
 rtl/wordcount_stream_ctrl.sv | 142 ++++++++++++++
 tb/tb_wordcount_stream_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/wordcount_pkg.sv
// wordcount_pkg: shared state encoding, command codes and summary beat layout
package wordcount_pkg;
  typedef enum logic [2:0] {IDLE, RD_START, STREAM, DRAIN, WR_START, WR_DATA, WR_WAIT} state_e;
  localparam logic [31:0] CMD_COUNT = 32'd1;
  localparam int WORDS_LSB = 0;
  localparam int HITS_LSB = 32;
  localparam int MISSES_LSB = 64;
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/wordcount_beat_splitter.sv
// wordcount_beat_splitter: holds one beat and presents its valid lanes one word per take, lane 0 first
module wordcount_beat_splitter
  import wordcount_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int KEY_WIDTH = 32,
  localparam int WPB = DATA_WIDTH / KEY_WIDTH,
  localparam int IW = $clog2(WPB + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [IW-1:0]         s_lanes,
  output logic                  w_valid,
  output logic [KEY_WIDTH-1:0]  w_key,
  output logic                  w_last,
  input  logic                  w_take
);
  logic                  hold_q, hold_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IW-1:0]         idx_q, idx_d, cnt_q, cnt_d;
  assign s_ready = !hold_q;
  assign w_valid = hold_q;
  assign w_key = KEY_WIDTH'(data_q >> (idx_q * KEY_WIDTH));
  assign w_last = idx_q == cnt_q - 1'b1;
  always_comb begin
    hold_d = hold_q;
    data_d = data_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (s_valid && s_ready) begin
      hold_d = 1'b1;
      data_d = s_data;
      idx_d = '0;
      cnt_d = s_lanes;
    end else if (w_take) begin
      hold_d = !w_last;
      idx_d = idx_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= 1'b0;
      data_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      hold_q <= hold_d;
      data_q <= data_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/wordcount_stream_ctrl.sv
// wordcount_stream_ctrl: streams words from the reader into the KVS search-and-add port
// and writes a one-beat words/hits/misses summary after the read buffer
module wordcount_stream_ctrl
  import wordcount_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int KEY_WIDTH = 32,
  parameter int ADDR_WIDTH = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  kick,
  output logic                  busy,
  input  logic [31:0]           command,
  input  logic [31:0]           num_of_words,
  input  logic [ADDR_WIDTH-1:0] global_memory_offset,
  output logic                  reader_ctrl_start,
  input  logic                  reader_ctrl_done,
  output logic [63:0]           reader_ctrl_addr_offset,
  output logic [63:0]           reader_ctrl_xfer_size_in_bytes,
  input  logic                  reader_s_axis_tvalid,
  output logic                  reader_s_axis_tready,
  input  logic [DATA_WIDTH-1:0] reader_s_axis_tdata,
  input  logic                  reader_s_axis_tlast,
  output logic                  kvs_req_valid,
  input  logic                  kvs_req_ready,
  output logic [KEY_WIDTH-1:0]  kvs_req_key,
  input  logic                  kvs_rsp_valid,
  input  logic                  kvs_rsp_hit,
  output logic                  writer_ctrl_start,
  input  logic                  writer_ctrl_done,
  output logic [63:0]           writer_ctrl_addr_offset,
  output logic [63:0]           writer_ctrl_xfer_size_in_bytes,
  output logic                  writer_m_axis_tvalid,
  input  logic                  writer_m_axis_tready,
  output logic [DATA_WIDTH-1:0] writer_m_axis_tdata
);
  localparam int WPB = DATA_WIDTH / KEY_WIDTH;
  localparam int BPB = DATA_WIDTH / 8;
  localparam int IW = $clog2(WPB + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  state_e                state_q, state_d;
  logic                  nop_q, nop_d, done_q, done_d;
  logic [31:0]           num_q, num_d, left_q, left_d;
  logic [31:0]           words_q, words_d, hits_q, hits_d, misses_q, misses_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [OW-1:0]         outst_q, outst_d;
  logic                  split_ready, w_valid, w_last, issue, rsp, beat, kick_ok;
  logic [IW-1:0]         lanes;
  logic [63:0]           rd_xfer;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  unused_tlast;
  assign unused_tlast = reader_s_axis_tlast;
  assign busy = state_q != IDLE || nop_q;
  assign rd_xfer = ((64'(num_q) + 64'(WPB - 1)) / 64'(WPB)) * 64'(BPB);
  assign reader_ctrl_start = state_q == RD_START;
  assign reader_ctrl_addr_offset = reader_ctrl_start ? 64'(addr_q) : '0;
  assign reader_ctrl_xfer_size_in_bytes = reader_ctrl_start ? rd_xfer : '0;
  assign writer_ctrl_start = state_q == WR_START;
  assign writer_ctrl_addr_offset = writer_ctrl_start ? 64'(addr_q) + rd_xfer : '0;
  assign writer_ctrl_xfer_size_in_bytes = writer_ctrl_start ? 64'(BPB) : '0;
  assign writer_m_axis_tvalid = state_q == WR_DATA;
  assign writer_m_axis_tdata = writer_m_axis_tvalid ? wdata : '0;
  assign reader_s_axis_tready = split_ready && state_q == STREAM && left_q != '0;
  assign kvs_req_valid = w_valid && state_q == STREAM && outst_q != OW'(MAX_OUTSTANDING);
  assign beat = reader_s_axis_tvalid && reader_s_axis_tready;
  assign issue = kvs_req_valid && kvs_req_ready;
  assign rsp = kvs_rsp_valid && outst_q != '0;
  assign kick_ok = kick && state_q == IDLE && !nop_q;
  assign lanes = (left_q >= 32'(WPB)) ? IW'(WPB) : IW'(left_q);
  wordcount_beat_splitter #(.DATA_WIDTH(DATA_WIDTH), .KEY_WIDTH(KEY_WIDTH)) u_split (
    .clk(clk), .reset(reset),
    .s_valid(reader_s_axis_tvalid && state_q == STREAM && left_q != '0),
    .s_ready(split_ready), .s_data(reader_s_axis_tdata), .s_lanes(lanes),
    .w_valid(w_valid), .w_key(kvs_req_key), .w_last(w_last), .w_take(issue)
  );
  always_comb begin
    wdata = '0;
    wdata[WORDS_LSB +: 32] = words_q;
    wdata[HITS_LSB +: 32] = hits_q;
    wdata[MISSES_LSB +: 32] = misses_q;
  end
  always_comb begin
    state_d = state_q;
    nop_d = 1'b0;
    num_d = num_q;
    addr_d = addr_q;
    left_d = beat ? left_q - 32'(lanes) : left_q;
    outst_d = outst_q + OW'(issue) - OW'(rsp);
    words_d = issue ? sat_inc(words_q) : words_q;
    hits_d = (rsp && kvs_rsp_hit) ? sat_inc(hits_q) : hits_q;
    misses_d = (rsp && !kvs_rsp_hit) ? sat_inc(misses_q) : misses_q;
    done_d = done_q || (reader_ctrl_done && (state_q == STREAM || state_q == DRAIN));
    case (state_q)
      IDLE: if (kick_ok) begin
        num_d = num_of_words;
        addr_d = global_memory_offset;
        left_d = num_of_words;
        outst_d = '0;
        words_d = '0;
        hits_d = '0;
        misses_d = '0;
        done_d = 1'b0;
        nop_d = command != CMD_COUNT;
        state_d = (command != CMD_COUNT) ? IDLE : (num_of_words == '0) ? WR_START : RD_START;
      end
      RD_START: state_d = STREAM;
      STREAM:   state_d = (issue && w_last && left_q == '0) ? DRAIN : STREAM;
      DRAIN:    state_d = (outst_q == '0 && done_q) ? WR_START : DRAIN;
      WR_START: state_d = WR_DATA;
      WR_DATA:  state_d = writer_m_axis_tready ? WR_WAIT : WR_DATA;
      WR_WAIT:  state_d = writer_ctrl_done ? IDLE : WR_WAIT;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      nop_q <= 1'b0;
      done_q <= 1'b0;
      num_q <= '0;
      left_q <= '0;
      addr_q <= '0;
      outst_q <= '0;
      words_q <= '0;
      hits_q <= '0;
      misses_q <= '0;
    end else begin
      state_q <= state_d;
      nop_q <= nop_d;
      done_q <= done_d;
      num_q <= num_d;
      left_q <= left_d;
      addr_q <= addr_d;
      outst_q <= outst_d;
      words_q <= words_d;
      hits_q <= hits_d;
      misses_q <= misses_d;
    end
  end
endmodule

// File: tb/tb_wordcount_stream_ctrl.sv
// tb_wordcount_stream_ctrl: job table plus random jobs against reader/KVS/writer models
module tb_wordcount_stream_ctrl;
  localparam int DW = 512, KW = 32, AW = 64, MO = 8, WPB = DW / KW, BPB = DW / 8;
  logic clk = 1'b0, reset;
  logic kick, busy;
  logic [31:0] command, num_of_words;
  logic [AW-1:0] global_memory_offset;
  logic reader_ctrl_start, reader_ctrl_done;
  logic [63:0] reader_ctrl_addr_offset, reader_ctrl_xfer_size_in_bytes;
  logic reader_s_axis_tvalid, reader_s_axis_tready, reader_s_axis_tlast;
  logic [DW-1:0] reader_s_axis_tdata;
  logic kvs_req_valid, kvs_req_ready, kvs_rsp_valid, kvs_rsp_hit;
  logic [KW-1:0] kvs_req_key;
  logic writer_ctrl_start, writer_ctrl_done;
  logic [63:0] writer_ctrl_addr_offset, writer_ctrl_xfer_size_in_bytes;
  logic writer_m_axis_tvalid, writer_m_axis_tready;
  logic [DW-1:0] writer_m_axis_tdata;
  logic any_out;
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  wordcount_stream_ctrl dut (
    .clk(clk), .reset(reset), .kick(kick), .busy(busy), .command(command),
    .num_of_words(num_of_words), .global_memory_offset(global_memory_offset),
    .reader_ctrl_start(reader_ctrl_start), .reader_ctrl_done(reader_ctrl_done),
    .reader_ctrl_addr_offset(reader_ctrl_addr_offset),
    .reader_ctrl_xfer_size_in_bytes(reader_ctrl_xfer_size_in_bytes),
    .reader_s_axis_tvalid(reader_s_axis_tvalid), .reader_s_axis_tready(reader_s_axis_tready),
    .reader_s_axis_tdata(reader_s_axis_tdata), .reader_s_axis_tlast(reader_s_axis_tlast),
    .kvs_req_valid(kvs_req_valid), .kvs_req_ready(kvs_req_ready), .kvs_req_key(kvs_req_key),
    .kvs_rsp_valid(kvs_rsp_valid), .kvs_rsp_hit(kvs_rsp_hit),
    .writer_ctrl_start(writer_ctrl_start), .writer_ctrl_done(writer_ctrl_done),
    .writer_ctrl_addr_offset(writer_ctrl_addr_offset),
    .writer_ctrl_xfer_size_in_bytes(writer_ctrl_xfer_size_in_bytes),
    .writer_m_axis_tvalid(writer_m_axis_tvalid), .writer_m_axis_tready(writer_m_axis_tready),
    .writer_m_axis_tdata(writer_m_axis_tdata)
  );
  assign any_out = |{busy, reader_ctrl_start, reader_ctrl_addr_offset, reader_ctrl_xfer_size_in_bytes,
                     reader_s_axis_tready, kvs_req_valid, kvs_req_key, writer_ctrl_start,
                     writer_ctrl_addr_offset, writer_ctrl_xfer_size_in_bytes, writer_m_axis_tvalid,
                     writer_m_axis_tdata};
  typedef struct {
    logic [31:0] cmd;
    logic [31:0] num;
    logic [63:0] off;
    logic [63:0] xfer;
    logic [63:0] waddr;
    bit stall;
    bit kmid;
    int rst_at;
  } job_t;
  job_t jobs[9];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic run_job(input job_t j);
    int cyc = 0, beats = 0, rd_st = 0, wr_st = 0, bcyc = 0, pend = 0, maxp = 0, viol = 0;
    int issued = 0, pushed = 0, rdone_cd = -1, wdone_cd = -1;
    logic [31:0] hits = 0, misses = 0;
    logic [KW-1:0] expq[$];
    logic [DW-1:0] wbeat = '0, nb;
    bit acc = 0, withhold, cnt;
    cnt = j.cmd == 32'd1;
    command = j.cmd;
    num_of_words = j.num;
    global_memory_offset = j.off;
    kick = 1'b1;
    @(negedge clk);
    kick = 1'b0;
    chk("busy_after_kick", busy, 1);
    forever begin
      reader_ctrl_done = 0; writer_ctrl_done = 0; kvs_rsp_valid = 0; kvs_rsp_hit = 0;
      kvs_req_ready = 0; writer_m_axis_tready = 0;
      if (j.kmid) begin
        kick = cyc == 10;
        if (cyc == 10) begin
          num_of_words = 32'd7;
          global_memory_offset = 64'hdead_0000;
        end
      end
      if (!busy) break;
      if (cyc >= 20000) begin
        chk("timeout", 1, 0);
        break;
      end
      if (cyc == j.rst_at) begin
        reset = 1'b1;
        kick = 1'b0;
        reader_s_axis_tvalid = 1'b0;
        @(negedge clk);
        chk("outs_in_reset", any_out, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("outs_after_reset", any_out, 0);
        return;
      end
      bcyc++;
      if (reader_ctrl_start) begin
        rd_st++;
        chk("rd_addr", reader_ctrl_addr_offset, j.off);
        chk("rd_xfer", reader_ctrl_xfer_size_in_bytes, j.xfer);
        beats = (int'(j.num) + WPB - 1) / WPB;
      end
      if (acc) reader_s_axis_tvalid = 1'b0;
      if (!reader_s_axis_tvalid && beats > 0 && rd_st > 0 && $urandom_range(0, 3) != 0) begin
        for (int i = 0; i < DW / 32; i++) nb[i*32 +: 32] = $urandom;
        reader_s_axis_tdata = nb;
        reader_s_axis_tlast = beats == 1;
        reader_s_axis_tvalid = 1'b1;
      end
      acc = reader_s_axis_tvalid && reader_s_axis_tready;
      if (acc) begin
        beats--;
        for (int i = 0; i < WPB && pushed < int'(j.num); i++) begin
          expq.push_back(reader_s_axis_tdata[i*KW +: KW]);
          pushed++;
        end
        if (beats == 0) rdone_cd = $urandom_range(0, 6);
      end
      if (rdone_cd == 0) reader_ctrl_done = 1'b1;
      if (rdone_cd >= 0) rdone_cd--;
      if (pend == MO && kvs_req_valid) viol++;
      withhold = j.stall && cyc < 150;
      if (pend > 0 && !withhold && $urandom_range(0, 2) == 0) begin
        kvs_rsp_valid = 1'b1;
        kvs_rsp_hit = 1'($urandom_range(0, 1));
        if (kvs_rsp_hit) hits++; else misses++;
        pend--;
      end else if (pend == 0 && $urandom_range(0, 7) == 0) begin
        kvs_rsp_valid = 1'b1;
        kvs_rsp_hit = 1'b1;
      end
      kvs_req_ready = (j.stall && cyc < 50) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (kvs_req_valid && kvs_req_ready) begin
        if (expq.size() == 0) chk("key_extra", 1, 0);
        else chk("key", kvs_req_key, expq.pop_front());
        issued++;
        pend++;
        if (pend > maxp) maxp = pend;
      end
      if (writer_ctrl_start) begin
        wr_st++;
        chk("wr_addr", writer_ctrl_addr_offset, j.waddr);
        chk("wr_xfer", writer_ctrl_xfer_size_in_bytes, BPB);
      end
      writer_m_axis_tready = 1'($urandom_range(0, 1));
      if (writer_m_axis_tvalid && writer_m_axis_tready) begin
        wbeat = writer_m_axis_tdata;
        wdone_cd = $urandom_range(1, 5);
      end
      if (wdone_cd == 0) writer_ctrl_done = 1'b1;
      if (wdone_cd >= 0) wdone_cd--;
      @(negedge clk);
      cyc++;
    end
    reader_s_axis_tvalid = 1'b0;
    kick = 1'b0;
    chk("rd_starts", rd_st, (cnt && j.num != 0) ? 1 : 0);
    chk("wr_starts", wr_st, cnt ? 1 : 0);
    if (!cnt) chk("nop_busy_cycles", bcyc, 1);
    else begin
      chk("issued", issued, j.num);
      chk("full_valid_viol", viol, 0);
      if (j.stall) chk("max_outstanding", maxp, MO);
      else chk("over_outstanding", maxp > MO, 0);
      chk("sum_words", wbeat[31:0], j.num);
      chk("sum_hits", wbeat[63:32], hits);
      chk("sum_misses", wbeat[95:64], misses);
      chk("sum_rsvd", |wbeat[DW-1:96], 0);
    end
  endtask
  initial begin
    reset = 1'b1; kick = 0; command = 0; num_of_words = 0; global_memory_offset = 0;
    reader_ctrl_done = 0; reader_s_axis_tvalid = 0; reader_s_axis_tdata = '0; reader_s_axis_tlast = 0;
    kvs_req_ready = 0; kvs_rsp_valid = 0; kvs_rsp_hit = 0; writer_ctrl_done = 0; writer_m_axis_tready = 0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outs", any_out, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_outs", any_out, 0);
    jobs[0] = '{cmd: 1, num: 128, off: 64'h8000_0000, xfer: 512, waddr: 64'h8000_0200, stall: 0, kmid: 0, rst_at: -1};
    jobs[1] = '{cmd: 1, num: 20, off: 64'h1000, xfer: 128, waddr: 64'h1080, stall: 0, kmid: 0, rst_at: -1};
    jobs[2] = '{cmd: 1, num: 0, off: 64'h4000, xfer: 0, waddr: 64'h4000, stall: 0, kmid: 0, rst_at: -1};
    jobs[3] = '{cmd: 2, num: 16, off: 64'h0, xfer: 0, waddr: 0, stall: 0, kmid: 0, rst_at: -1};
    jobs[4] = '{cmd: 1, num: 16, off: 64'h0, xfer: 64, waddr: 64'h40, stall: 0, kmid: 0, rst_at: -1};
    jobs[5] = '{cmd: 1, num: 17, off: 64'h100, xfer: 128, waddr: 64'h180, stall: 0, kmid: 0, rst_at: -1};
    jobs[6] = '{cmd: 1, num: 100, off: 64'h0, xfer: 448, waddr: 64'h1c0, stall: 1, kmid: 1, rst_at: -1};
    jobs[7] = '{cmd: 1, num: 128, off: 64'h0, xfer: 512, waddr: 64'h200, stall: 0, kmid: 0, rst_at: 30};
    jobs[8] = '{cmd: 1, num: 33, off: 64'h200, xfer: 192, waddr: 64'h2c0, stall: 0, kmid: 0, rst_at: -1};
    foreach (jobs[i]) run_job(jobs[i]);
    for (int r = 0; r < 6; r++) begin
      job_t j;
      j.cmd = ($urandom_range(0, 4) == 0) ? 32'd5 : 32'd1;
      j.num = $urandom_range(1, 300);
      j.off = {32'h0, $urandom} & 64'hffff_ffc0;
      j.xfer = ((64'(j.num) + WPB - 1) / WPB) * BPB;
      j.waddr = j.off + j.xfer;
      j.stall = 0;
      j.kmid = 0;
      j.rst_at = -1;
      run_job(j);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
